div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter n, default 8: operand width of a and b.
REQ-002 Parameter p, default 8: divider datapath width; p >= n.
REQ-003 Parameter TMO, default 32: maximum cycles to wait for div_done.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; asserted low clears all state immediately.
REQ-006 in_valid  input  1  upstream operand pair valid.
REQ-007 in_ready  output  1  sequencer can accept an operand pair.
REQ-008 a  input  n  signed dividend.
REQ-009 b  input  n  signed divisor.
REQ-010 div_clr  output  1  active-high clear to the divider's asynchronous reset; one-cycle pulse.
REQ-011 div_start  output  1  one-cycle start pulse to the divider.
REQ-012 div_x  output  p  dividend magnitude, zero-extended.
REQ-013 div_y  output  p  divisor magnitude, zero-extended.
REQ-014 div_quotient  input  p  raw quotient from the divider.
REQ-015 div_remainder  input  p  raw signed remainder from the divider.
REQ-016 div_done  input  1  divider completion level; stays high until the divider is cleared.
REQ-017 out_valid  output  1  result valid.
REQ-018 out_ready  input  1  downstream accepts the result.
REQ-019 quo  output  p  signed quotient, truncated toward zero.
REQ-020 rem  output  p  signed remainder, same sign as dividend.
REQ-021 dbz  output  1  divide-by-zero flag, valid with out_valid.
REQ-022 err  output  1  timeout flag, valid with out_valid.

Function
REQ-023 States: IDLE, CLR, START, WAIT, FIX, SIGN, OUT.
REQ-024 in_ready is high only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-025 On transfer: register a, b, sa = a[n-1], sb = b[n-1], and the magnitudes |a|, |b| as unsigned n-bit values (|-2^(n-1)| = 2^(n-1)).
REQ-026 On a transfer with b == 0: go directly to OUT; quo = all ones, rem = a sign-extended to p bits, dbz = 1; the divider is not touched.
REQ-027 On a transfer with b != 0: go to CLR.
REQ-028 CLR: div_clr = 1 for exactly one cycle, then go to START.
REQ-029 START: div_start = 1 for exactly one cycle; div_x and div_y hold the magnitudes from CLR until leaving WAIT; then go to WAIT.
REQ-030 WAIT: the wait counter starts at 0 and increments each cycle.
REQ-031 WAIT: div_done sampled high -> capture div_quotient and div_remainder, go to FIX.
REQ-032 WAIT: counter reaches TMO with div_done low -> go to OUT with quo = 0, rem = 0, err = 1.
REQ-033 div_done is ignored outside WAIT; a stale high level cannot complete a transaction because CLR precedes every START.
REQ-034 FIX: if raw remainder bit p-1 = 1, rem_m = raw remainder + |b| and quo_m = raw quotient - 1 (mod 2^p); otherwise pass both through; one cycle; then go to SIGN.
REQ-035 SIGN: quo = -quo_m if sa != sb, else quo_m; rem = -rem_m if sa = 1, else rem_m; two's complement mod 2^p; one cycle; then go to OUT.
REQ-036 OUT: out_valid = 1; quo, rem, dbz and err stay stable until out_valid && out_ready, then return to IDLE.
REQ-037 OUT: out_ready may be held low indefinitely; the block stalls with no loss and accepts no new input.
REQ-038 div_clr, div_start and out_valid are registered outputs and never assert in the same cycle.
REQ-039 Latency for b != 0: in-transfer edge to out_valid = 2 (CLR, START) + divider cycles + 2 (FIX, SIGN) + 1 cycles.
REQ-040 Latency for b == 0: out_valid is high the cycle after the transfer.

Reset
REQ-041 With reset low: state = IDLE, wait counter = 0, in_ready = 1 (combinational from state), div_clr = 0, div_start = 0, div_x = 0, div_y = 0, out_valid = 0, quo = 0, rem = 0, dbz = 0, err = 0.
REQ-042 Reset asserted in any state, including mid-WAIT, aborts the transaction with no result; after release the block is in IDLE, and the next transaction still issues div_clr before div_start.

Verification
REQ-043 a = 7, b = 2, out_ready = 1 -> div_clr, then div_start, div_x = 7, div_y = 2; quo = 0x03, rem = 0x01, dbz = 0, err = 0.
REQ-044 a = -7 (0xF9), b = 2 -> quo = 0xFD, rem = 0xFF; a = 7, b = -2 -> quo = 0xFD, rem = 0x01.
REQ-045 a = 5, b = 0 -> out_valid the next cycle; quo = 0xFF, rem = 0x05, dbz = 1; div_clr and div_start never pulse.
REQ-046 div_done tied low -> after TMO = 32 WAIT cycles: out_valid = 1, err = 1, quo = 0, rem = 0.
REQ-047 out_ready low for 10 cycles in OUT -> outputs stable, in_ready = 0 throughout; completes on the first cycle out_ready = 1.
REQ-048 Reset pulled low mid-WAIT -> all outputs return to reset values immediately; a new a = 9, b = 3 then yields quo = 0x03, rem = 0x00.

Source files
------------

// File: rtl/div_sequencer.sv
// Sequences one signed division through an unsigned magnitude divider:
// clears it, starts it, waits for completion or a timeout, then fixes up and signs the result.
module div_sequencer #(
  parameter int n   = 8,
  parameter int p   = 8,
  parameter int TMO = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         div_clr,
  output logic         div_start,
  output logic [p-1:0] div_x,
  output logic [p-1:0] div_y,
  input  logic [p-1:0] div_quotient,
  input  logic [p-1:0] div_remainder,
  input  logic         div_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [p-1:0] quo,
  output logic [p-1:0] rem,
  output logic         dbz,
  output logic         err
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, FIX, SIGN, OUT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sa;
  logic          sb;
  logic [n-1:0]  mag_b;
  logic [p-1:0]  quo_m;
  logic [p-1:0]  rem_m;
  logic [n-1:0]  abs_a;
  logic [n-1:0]  abs_b;

  // Unsigned n-bit magnitudes; the most negative value maps onto 2^(n-1).
  assign abs_a    = a[n-1] ? -a : a;
  assign abs_b    = b[n-1] ? -b : b;
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      mag_b     <= '0;
      quo_m     <= '0;
      rem_m     <= '0;
      div_clr   <= 1'b0;
      div_start <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
      out_valid <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dbz       <= 1'b0;
      err       <= 1'b0;
    end else begin
      div_clr   <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a[n-1];
            sb    <= b[n-1];
            mag_b <= abs_b;
            dbz   <= 1'b0;
            err   <= 1'b0;
            if (b == '0) begin
              // Divide by zero never reaches the divider.
              quo       <= '1;
              rem       <= p'(signed'(a));
              dbz       <= 1'b1;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              div_x   <= p'(abs_a);
              div_y   <= p'(abs_b);
              div_clr <= 1'b1;
              state   <= CLR;
            end
          end
        end
        CLR: begin
          div_start <= 1'b1;
          cnt       <= '0;
          state     <= START;
        end
        START: state <= WAIT;
        WAIT: begin
          if (div_done) begin
            quo_m <= div_quotient;
            rem_m <= div_remainder;
            div_x <= '0;
            div_y <= '0;
            state <= FIX;
          end else if (cnt == CW'(TMO - 1)) begin
            quo       <= '0;
            rem       <= '0;
            err       <= 1'b1;
            out_valid <= 1'b1;
            div_x     <= '0;
            div_y     <= '0;
            state     <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          // A negative raw remainder means the quotient overshot by one.
          if (rem_m[p-1]) begin
            rem_m <= rem_m + p'(mag_b);
            quo_m <= quo_m - p'(1);
          end
          state <= SIGN;
        end
        SIGN: begin
          quo       <= (sa ^ sb) ? -quo_m : quo_m;
          rem       <= sa ? -rem_m : rem_m;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural divider model that can
// complete normally, return a non-restoring style result, or never finish.
module tb_div_sequencer;
  localparam int N = 8, P = 8, TMO = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         div_clr, div_start;
  logic [P-1:0] div_x, div_y;
  logic [P-1:0] div_quotient = '0;
  logic [P-1:0] div_remainder = '0;
  logic         div_done = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] quo, rem;
  logic         dbz, err;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.n(N), .p(P), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .div_clr(div_clr), .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .dbz(dbz), .err(err)
  );

  always #5 clk = ~clk;

  // Divider model: done stays high until the next clear.
  logic         hang = 1'b0;
  logic         nonres = 1'b0;
  int           dly = 3;
  logic         busy = 1'b0;
  int           dcnt = 0;
  logic [P-1:0] dx = '0, dy = '0;
  int           cyc = 0, clr_cnt = 0, start_cnt = 0, clr_cyc = 0, start_cyc = 0, overlap = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (int'(div_clr) + int'(div_start) + int'(out_valid) > 1) overlap <= overlap + 1;
    if (div_clr) begin
      div_done <= 1'b0;
      busy     <= 1'b0;
      clr_cnt  <= clr_cnt + 1;
      clr_cyc  <= cyc;
    end else if (div_start) begin
      busy      <= 1'b1;
      dcnt      <= dly;
      dx        <= div_x;
      dy        <= div_y;
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end else if (busy && !hang) begin
      if (dcnt <= 1) begin
        busy          <= 1'b0;
        div_done      <= 1'b1;
        div_quotient  <= (dx / dy) + (nonres ? P'(1) : P'(0));
        div_remainder <= (dx % dy) - (nonres ? dy : P'(0));
      end else begin
        dcnt <= dcnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the transfer happens on the following rising edge.
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic expect_result(input string tag, input logic [P-1:0] q, input logic [P-1:0] r,
                               input logic d, input logic e);
    $display("txn %s: quo=%02h rem=%02h dbz=%0d err=%0d", tag, quo, rem, dbz, err);
    chk({tag, "_quo"}, quo, q);
    chk({tag, "_rem"}, rem, r);
    chk({tag, "_dbz"}, dbz, d);
    chk({tag, "_err"}, err, e);
    chk({tag, "_busy"}, in_ready, 0);
    @(negedge clk);
    chk({tag, "_done"}, out_valid, 0);
  endtask

  task automatic do_div(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [P-1:0] q, input logic [P-1:0] r);
    int c0, s0, lat;
    c0 = clr_cnt;
    s0 = start_cnt;
    send(av, bv);
    wait_out(lat);
    expect_result(tag, q, r, 1'b0, 1'b0);
    chk({tag, "_clr_once"}, clr_cnt - c0, 1);
    chk({tag, "_start_once"}, start_cnt - s0, 1);
    chk({tag, "_clr_then_start"}, start_cyc - clr_cyc, 1);
  endtask

  initial begin
    int lat, c0, s0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_div_clr", div_clr, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_x", div_x, 0);
    chk("rst_div_y", div_y, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quo", quo, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);

    // 7 / 2 with the handshake to the divider observed cycle by cycle
    send(8'd7, 8'd2);
    @(negedge clk);
    chk("clr_pulse", div_clr, 1);
    chk("clr_no_start", div_start, 0);
    chk("clr_x", div_x, 7);
    chk("clr_y", div_y, 2);
    @(negedge clk);
    chk("start_pulse", div_start, 1);
    chk("start_no_clr", div_clr, 0);
    chk("start_x", div_x, 7);
    chk("start_y", div_y, 2);
    wait_out(lat);
    expect_result("7/2", 8'h03, 8'h01, 1'b0, 1'b0);

    do_div("-7/2", 8'hF9, 8'h02, 8'hFD, 8'hFF);
    do_div("7/-2", 8'h07, 8'hFE, 8'hFD, 8'h01);
    chk("7/-2_y_mag", dy, 8'h02);

    // Overshooting divider exercises the remainder fix-up
    nonres = 1'b1;
    do_div("7/2_fix", 8'h07, 8'h02, 8'h03, 8'h01);
    do_div("-128/3_fix", 8'h80, 8'h03, 8'hD6, 8'hFE);
    chk("-128_x_mag", dx, 8'h80);
    nonres = 1'b0;

    // Divide by zero
    c0 = clr_cnt; s0 = start_cnt;
    send(8'd5, 8'd0);
    wait_out(lat);
    chk("dbz_latency", lat, 1);
    expect_result("5/0", 8'hFF, 8'h05, 1'b1, 1'b0);
    send(8'hFB, 8'd0);
    wait_out(lat);
    expect_result("-5/0", 8'hFF, 8'hFB, 1'b1, 1'b0);
    chk("dbz_no_clr", clr_cnt - c0, 0);
    chk("dbz_no_start", start_cnt - s0, 0);

    // Timeout
    hang = 1'b1;
    send(8'd1, 8'd1);
    wait_out(lat);
    chk("tmo_latency", (lat >= 34 && lat <= 35), 1);
    expect_result("tmo", 8'h00, 8'h00, 1'b0, 1'b1);
    hang = 1'b0;

    // Output stall with a competing input offered throughout
    out_ready = 1'b0;
    c0 = clr_cnt;
    send(8'd9, 8'd2);
    wait_out(lat);
    a = 8'd1; b = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_quo", quo, 8'h04);
      chk("stall_rem", rem, 8'h01);
      chk("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    $display("txn stall 9/2: released, out_valid=%0d", out_valid);
    chk("stall_release", out_valid, 0);
    chk("stall_idle", in_ready, 1);
    chk("stall_no_accept", clr_cnt - c0, 1);

    // Reset in the middle of WAIT
    hang = 1'b1;
    send(8'd3, 8'd1);
    repeat (6) @(negedge clk);
    chk("midwait_x", div_x, 3);
    reset = 1'b0;
    #1;
    $display("txn reset mid-WAIT: out_valid=%0d in_ready=%0d div_x=%02h", out_valid, in_ready, div_x);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_div_x", div_x, 0);
    chk("arst_div_y", div_y, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_err", err, 0);
    chk("arst_quo", quo, 0);
    @(negedge clk);
    reset = 1'b1;
    hang = 1'b0;
    @(negedge clk);
    do_div("9/3", 8'd9, 8'd3, 8'h03, 8'h00);

    chk("no_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
